clk_div_bank: RTL

Synthesizable, parametrised successor to the singleton clock generator. Produces N_CH independent divided clocks from one reference clock. Each channel has a programmable period and high time, a glitch-free start/stop, and config updates applied on period boundaries. Sits in the DUT-side clocking infrastructure and also serves as an emulation-friendly clock source for agents.

---
 rtl/clk_div_bank_pkg.sv | 36 +++
 rtl/clk_div_bank_if.sv | 37 +++
 rtl/clk_div_chan.sv | 118 +++++++++++
 rtl/clk_div_bank.sv | 84 ++++++++
 4 files changed

// File: rtl/clk_div_bank_pkg.sv
// clk_div_bank shared types and helpers.
// Channel state, config bundle, validity rule.
package clk_div_bank_pkg;

  localparam int unsigned DEF_DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } chan_state_e;

  typedef struct packed {
    logic [DEF_DIV_W-1:0] period;
    logic [DEF_DIV_W-1:0] high;
  } cfg_t;

  function automatic int unsigned ch_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic cfg_is_valid(
    input logic [31:0] period,
    input logic [31:0] high,
    input logic [31:0] ch,
    input logic [31:0] n_ch
  );
    return (period >= 32'd2) &&
           (high >= 32'd1) &&
           (high < period) &&
           (ch < n_ch);
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank config write port.
// valid/ready transfer plus a rejection pulse.
interface clk_div_bank_if
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = DEF_DIV_W
);

  localparam int unsigned CH_W = ch_w(N_CH);

  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [CH_W-1:0]  cfg_ch_i;
  logic [DIV_W-1:0] cfg_period_i;
  logic [DIV_W-1:0] cfg_high_i;
  logic             cfg_err_o;

  modport master (
    output cfg_valid_i,
    output cfg_ch_i,
    output cfg_period_i,
    output cfg_high_i,
    input  cfg_ready_o,
    input  cfg_err_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_ch_i,
    input  cfg_period_i,
    input  cfg_high_i,
    output cfg_ready_o,
    output cfg_err_o
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divided-clock channel.
// FSM, counter, active/shadow cfg, registered clk/rise.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned DIV_W      = DEF_DIV_W,
  parameter int unsigned DEF_PERIOD = 4,
  parameter int unsigned DEF_HIGH   = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic wr_i,
  input  cfg_t wr_cfg_i,
  output logic clk_o,
  output logic rise_o,
  output logic running_o,
  output logic pending_o
);

  localparam cfg_t DEF_CFG = '{
    period: DEF_DIV_W'(DEF_PERIOD),
    high:   DEF_DIV_W'(DEF_HIGH)
  };

  chan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  cfg_t             act_q, act_d;
  cfg_t             shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;

  logic [DIV_W-1:0] per;
  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] nxt;
  logic             wrap;
  logic             apply;

  // Next state: count, wrap, boundary apply, stop at period end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;

    per   = DIV_W'(act_q.period);
    wrap  = (cnt_q == per - DIV_W'(1));
    apply = pend_q && ((state_q == IDLE) || wrap);
    hi    = apply ? DIV_W'(shd_q.high)
                  : DIV_W'(act_q.high);
    nxt   = wrap ? '0 : cnt_q + DIV_W'(1);

    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    // A write is only accepted while nothing is pending.
    if (wr_i) begin
      shd_d  = wr_cfg_i;
      pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = RUN;
          cnt_d   = '0;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (wrap && !en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          clk_d   = 1'b0;
        end else begin
          state_d = en_i ? RUN : STOPPING;
          cnt_d   = nxt;
          clk_d   = (nxt < hi);
          rise_d  = wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel registers; reset drops the clock and any shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= DEF_CFG;
      shd_q   <= DEF_CFG;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
    end
  end

  assign clk_o     = clk_q;
  assign rise_o    = rise_q;
  assign running_o = (state_q != IDLE);
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable clock dividers.
// Config decode, ready mux, error pulse.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DIV_W      = DEF_DIV_W,
  parameter int unsigned DEF_PERIOD = 4,
  parameter int unsigned DEF_HIGH   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] en_i,
  clk_div_bank_if.slave   cfg,
  output logic [N_CH-1:0] clk_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] running_o,
  output logic [N_CH-1:0] pending_o
);

  localparam int unsigned CH_W = ch_w(N_CH);
  localparam int unsigned PAD  = 1 << CH_W;

  logic [PAD-1:0]  pend_pad;
  logic            fire;
  logic            good;
  logic [N_CH-1:0] wr;
  cfg_t            wr_cfg;
  logic            err_q, err_d;

  // Decode a transfer into a per-channel write or a reject.
  always_comb begin
    pend_pad = '0;
    pend_pad[N_CH-1:0] = pending_o;
    fire = cfg.cfg_valid_i && cfg.cfg_ready_o;
    good = cfg_is_valid(
      32'(cfg.cfg_period_i),
      32'(cfg.cfg_high_i),
      32'(cfg.cfg_ch_i),
      32'(N_CH)
    );
    wr_cfg = '{
      period: DEF_DIV_W'(cfg.cfg_period_i),
      high:   DEF_DIV_W'(cfg.cfg_high_i)
    };
    for (int i = 0; i < N_CH; i++) begin
      wr[i] = fire && good &&
              (cfg.cfg_ch_i == CH_W'(i));
    end
    err_d = fire && !good;
  end

  // One-cycle reject pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // Out-of-range channels read as not pending.
  assign cfg.cfg_ready_o = ~pend_pad[cfg.cfg_ch_i];
  assign cfg.cfg_err_o   = err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_chan #(
      .DIV_W      (DIV_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (en_i[g]),
      .wr_i      (wr[g]),
      .wr_cfg_i  (wr_cfg),
      .clk_o     (clk_o[g]),
      .rise_o    (rise_o[g]),
      .running_o (running_o[g]),
      .pending_o (pending_o[g])
    );
  end

endmodule
